filter_sequencer: RTL and testbench

FILTER_SEQUENCER -- requirements
Module: filter_sequencer

---
 rtl/filter_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_filter_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sequencer.sv
// filter_sequencer
//   Sequences one frame of pixel words through an external filter datapath.
//   A start pulse in IDLE shadows the mode and brightness coefficient. The
//   frame then runs one pixel at a time:
//     FETCH : accept one input word and register it onto filt_in
//     WAIT  : let the datapath settle for FILT_LAT cycles, then capture
//             filt_result
//     OUT   : present the result until downstream takes it
//   After the last pixel is accepted, the block pulses frame_done and returns
//   to IDLE.
//
// Parameters
//   FRAME_PIXELS : pixel words per frame (1..65535)
//   FILT_LAT     : filter datapath settle time in cycles (1..15)
//
// Ports
//   clk          : single clock, rising edge
//   n_rst        : asynchronous reset, active HIGH despite the name
//   start        : frame start pulse, ignored while busy
//   cfg_mode     : mode, shadowed onto filt_mode at frame start
//   cfg_beta     : coefficient, shadowed onto filt_beta at frame start
//   in_valid     : input word valid
//   in_data      : input word
//   in_ready     : input word accepted this cycle (FETCH only)
//   filt_in      : registered word driven to the filter datapath
//   filt_mode    : shadowed mode driven to the filter datapath
//   filt_beta    : shadowed coefficient driven to the filter datapath
//   filt_result  : filter datapath result
//   out_valid    : out_data valid (OUT only)
//   out_data     : captured filter result, held until out_ready
//   out_ready    : downstream accepts out_data
//   busy         : high in every state except IDLE
//   frame_done   : one-cycle pulse after the last pixel of a frame is taken
//   frame_count  : completed frames, 16-bit wrapping. This port exists only
//                  when FILTER_SEQ_FRAME_CNT_EN is defined.
//
// Optional feature macro: FILTER_SEQ_FRAME_CNT_EN

module filter_sequencer #(
   parameter int FRAME_PIXELS = 16,
   parameter int FILT_LAT     = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [1:0]  cfg_mode,
   input  logic [7:0]  cfg_beta,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic [31:0] filt_in,
   output logic [1:0]  filt_mode,
   output logic [7:0]  filt_beta,
   input  logic [31:0] filt_result,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        frame_done
`ifdef FILTER_SEQ_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam logic [15:0] LAST_PIX = 16'(FRAME_PIXELS - 1);
   localparam logic [3:0]  LAT_INIT = 4'(FILT_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t      state;
   state_t      nextState;
   logic [15:0] pixCnt;
   logic [3:0]  latCnt;
   logic        lastPix;
   logic        startFrame;
   logic        acceptIn;
   logic        captureOut;
   logic        acceptOut;

   assign lastPix = (pixCnt == LAST_PIX);

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState  = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      startFrame = 1'b0;
      acceptIn   = 1'b0;
      captureOut = 1'b0;
      acceptOut  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               startFrame = 1'b1;
               nextState  = FETCH;
            end
         end
         FETCH: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acceptIn  = 1'b1;
               nextState = WAIT;
            end
         end
         WAIT: begin
            // The <= also covers a zero count, so a bad count can never
            // hang the FSM in WAIT.
            if (latCnt <= 4'd1) begin
               captureOut = 1'b1;
               nextState  = OUT;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acceptOut = 1'b1;
               nextState = lastPix ? IDLE : FETCH;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Stage boundary: frame shadow and input register feeding the datapath.
   // Stage boundary: result capture after the settle time has elapsed.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         filt_in    <= '0;
         filt_mode  <= '0;
         filt_beta  <= '0;
         out_data   <= '0;
         pixCnt     <= '0;
         latCnt     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= acceptOut && lastPix;
         if (startFrame) begin
            filt_mode <= cfg_mode;
            filt_beta <= cfg_beta;
            pixCnt    <= '0;
         end
         if (acceptIn) begin
            filt_in <= in_data;
            latCnt  <= LAT_INIT;
         end else if (state == WAIT && latCnt != 4'd0) begin
            latCnt <= latCnt - 4'd1;
         end
         if (captureOut) begin
            out_data <= filt_result;
         end
         if (acceptOut && !lastPix) begin
            pixCnt <= pixCnt + 16'd1;
         end
      end
   end

`ifdef FILTER_SEQ_FRAME_CNT_EN
   // Counts on the same edge that raises frame_done, so the new value
   // appears together with the pulse. It wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         frame_count <= '0;
      end else if (acceptOut && lastPix) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_filter_sequencer.sv
// Testbench for filter_sequencer: table-driven frame with scoreboard,
// plus hand-written mid-frame start, stall and reset-abort sequences.
// The filter datapath is stood in for by a small combinational model.

module tb_filter_sequencer;

   localparam int FRAME_PIXELS = 16;
   localparam int FILT_LAT     = 2;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  cfg_mode = '0;
   logic [7:0]  cfg_beta = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic [31:0] filt_in;
   logic [1:0]  filt_mode;
   logic [7:0]  filt_beta;
   logic [31:0] filt_result;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        frame_done;
`ifdef FILTER_SEQ_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   always #5 clk = ~clk;

   filter_sequencer #(
      .FRAME_PIXELS (FRAME_PIXELS),
      .FILT_LAT     (FILT_LAT)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .cfg_mode    (cfg_mode),
      .cfg_beta    (cfg_beta),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .filt_in     (filt_in),
      .filt_mode   (filt_mode),
      .filt_beta   (filt_beta),
      .filt_result (filt_result),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .busy        (busy),
      .frame_done  (frame_done)
`ifdef FILTER_SEQ_FRAME_CNT_EN
      ,
      .frame_count (frame_count)
`endif
   );

   // Stand-in filter datapath.
   function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m,
                                         input logic [7:0] b);
      return (d + {24'd0, b}) ^ {m, 30'd0};
   endfunction

   logic tieA5 = 1'b0;
   assign filt_result = tieA5 ? 32'hA5A5A5A5 : model(filt_in, filt_mode, filt_beta);

   typedef struct {
      logic [31:0] data;
      int          stall;
      bit          tie;
      logic [31:0] expResult;
   } vec_t;

   vec_t        vecs[FRAME_PIXELS];
   logic [31:0] sbQ[$];
   int          nChecks = 0;
   int          nErrors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nErrors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one pixel from FETCH through acceptance. Entered and left at
   // posedge+1.
   task automatic doPixel(input logic [31:0] d, input logic [31:0] expR, input bit tie,
                          input int stall, input bit isLast);
      int          cyc;
      logic [31:0] hold;
      logic [31:0] exp;
      check("in_ready_fetch", {31'd0, in_ready}, 32'd1);
      tieA5     = tie;
      out_ready = (stall == 0);
      in_valid  = 1'b1;
      in_data   = d;
      sbQ.push_back(expR);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      check("latency", 32'(cyc), 32'(FILT_LAT + 1));
      if (out_valid) begin
         hold = out_data;
         for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold", out_data, hold);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         end
         if (sbQ.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL scoreboard: got %h, expected queue entry (queue empty)", out_data);
         end else begin
            exp = sbQ.pop_front();
            check("out_data", out_data, exp);
         end
         out_ready = 1'b1;
         tick();
         tieA5 = 1'b0;
         check("frame_done", {31'd0, frame_done}, {31'd0, isLast});
         check("busy_after", {31'd0, busy}, {31'd0, !isLast});
         check("out_valid_after", {31'd0, out_valid}, 32'd0);
      end
   endtask

   task automatic startFrame(input logic [1:0] m, input logic [7:0] b);
      cfg_mode = m;
      cfg_beta = b;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("start_mode", {30'd0, filt_mode}, {30'd0, m});
      check("start_beta", {24'd0, filt_beta}, {24'd0, b});
      check("start_busy", {31'd0, busy}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;

      // Frame 1 vectors: mode 01, beta 40. Pixel 0 uses the tied result.
      for (int i = 0; i < FRAME_PIXELS; i++) begin
         case (i)
            1:       d = 32'h00000000;
            2:       d = 32'hFFFFFFFF;
            default: d = 32'h0F0F0000 + 32'(i) * 32'h01010101;
         endcase
         vecs[i].data      = d;
         vecs[i].stall     = (i == 3) ? 5 : (i == 9) ? 1 : 0;
         vecs[i].tie       = 1'b0;
         vecs[i].expResult = model(d, 2'b01, 8'h40);
      end
      vecs[0].data      = 32'h11223344;
      vecs[0].tie       = 1'b1;
      vecs[0].expResult = 32'hA5A5A5A5;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_filt_in", filt_in, 32'd0);
      check("rst_filt_mode", {30'd0, filt_mode}, 32'd0);
      check("rst_filt_beta", {24'd0, filt_beta}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
`ifdef FILTER_SEQ_FRAME_CNT_EN
      check("rst_frame_count", {16'd0, frame_count}, 32'd0);
`endif
      n_rst = 1'b0;
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Frame 1: table-driven, with a mid-frame start/cfg change before pixel 5
      startFrame(2'b01, 8'h40);
      for (int i = 0; i < FRAME_PIXELS; i++) begin
         if (i == 5) begin
            cfg_mode = 2'b11;
            cfg_beta = 8'h99;
            start    = 1'b1;
            tick();
            start = 1'b0;
            check("mid_start_mode", {30'd0, filt_mode}, 32'd1);
            check("mid_start_beta", {24'd0, filt_beta}, 32'h40);
            check("mid_start_busy", {31'd0, busy}, 32'd1);
         end
         doPixel(vecs[i].data, vecs[i].expResult, vecs[i].tie, vecs[i].stall,
                 i == FRAME_PIXELS - 1);
      end
`ifdef FILTER_SEQ_FRAME_CNT_EN
      check("frame_count_1", {16'd0, frame_count}, 32'd1);
`endif
      tick();
      check("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
      check("idle_after_frame", {31'd0, busy}, 32'd0);

      // Frame 2: mode 10, aborted by reset during WAIT of pixel 7
      startFrame(2'b10, 8'hC3);
      for (int i = 0; i < 7; i++) begin
         d = $urandom;
         doPixel(d, model(d, 2'b10, 8'hC3), 1'b0, 0, 1'b0);
      end
      check("p7_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      #2;
      n_rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd0);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_filt_in", filt_in, 32'd0);
      check("arst_filt_mode", {30'd0, filt_mode}, 32'd0);
      check("arst_filt_beta", {24'd0, filt_beta}, 32'd0);
      check("arst_out_data", out_data, 32'd0);
      check("arst_frame_done", {31'd0, frame_done}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("arst_hold_frame_done", {31'd0, frame_done}, 32'd0);
      end
`ifdef FILTER_SEQ_FRAME_CNT_EN
      check("arst_frame_count", {16'd0, frame_count}, 32'd0);
`endif
      n_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_idle", {31'd0, busy}, 32'd0);
         check("post_rst_no_done", {31'd0, frame_done}, 32'd0);
      end

      // Frame 3: full frame with mode 11 after the abort
      startFrame(2'b11, 8'hFF);
      for (int i = 0; i < FRAME_PIXELS; i++) begin
         d = $urandom;
         doPixel(d, model(d, 2'b11, 8'hFF), 1'b0, (i == 12) ? 2 : 0,
                 i == FRAME_PIXELS - 1);
      end
`ifdef FILTER_SEQ_FRAME_CNT_EN
      check("frame_count_3", {16'd0, frame_count}, 32'd1);
`endif
      tick();
      check("frame3_done_clear", {31'd0, frame_done}, 32'd0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
